// File: rtl/result_reader.sv
// result_reader: streams DEPTH words from a synchronous-read result memory onto a valid/ready port
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   start     run request level; a run begins when it falls after being seen high
//   mem_re    result-memory read enable (asserted only while requesting a word)
//   mem_addr  result-memory read address (always the word counter)
//   mem_data  result-memory read data, valid one cycle after mem_re
//   out_data  streamed result word
//   out_valid out_data holds a word waiting for out_ready
//   out_ready downstream accepts the word
//   busy      a run is in progress
//   done      one-cycle end-of-run pulse
module result_reader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {S_IDLE, S_ARM, S_REQ, S_WAIT, S_HOLD, S_DONE} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    state_t state, state_nx;
    logic [ADDR_W-1:0] cnt, cnt_nx;
    logic [DATA_W-1:0] data_nx;
    logic xfer;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            out_data <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            out_data <= data_nx;
        end
    end
    assign xfer = out_valid & out_ready;
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        data_nx  = out_data;
        case (state)
            S_IDLE: state_nx = start ? S_ARM : S_IDLE;
            S_ARM: begin
                cnt_nx   = '0;
                state_nx = start ? S_ARM : S_REQ;
            end
            S_REQ:  state_nx = S_WAIT;
            S_WAIT: begin
                data_nx  = mem_data;
                state_nx = S_HOLD;
            end
            S_HOLD: begin
                // the counter stops at the last address so it never wraps
                if (xfer) begin
                    state_nx = (cnt == LAST) ? S_DONE : S_REQ;
                    cnt_nx   = (cnt == LAST) ? cnt : cnt + 1'b1;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end
    // all outputs are decoded from registered state, so reset clears them immediately
    assign mem_re    = (state == S_REQ);
    assign mem_addr  = cnt;
    assign out_valid = (state == S_HOLD);
    assign busy      = (state == S_ARM) || (state == S_REQ) || (state == S_WAIT) || (state == S_HOLD);
    assign done      = (state == S_DONE);
endmodule

// File: tb/tb_result_reader.sv
// tb_result_reader: scoreboard bench for result_reader (DEPTH=16 instance a, DEPTH=1 instance b)
module tb_result_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b0;

    logic start_a = 1'b0, ready_a = 1'b0, re_a, valid_a, busy_a, done_a;
    logic [3:0] addr_a;
    logic [15:0] mdata_a, odata_a;
    logic start_b = 1'b0, ready_b = 1'b0, re_b, valid_b, busy_b, done_b;
    logic [3:0] addr_b;
    logic [15:0] mdata_b, odata_b;

    result_reader #(.DATA_W(16), .ADDR_W(4), .DEPTH(16)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .mem_re(re_a), .mem_addr(addr_a),
        .mem_data(mdata_a), .out_data(odata_a), .out_valid(valid_a), .out_ready(ready_a),
        .busy(busy_a), .done(done_a));
    result_reader #(.DATA_W(16), .ADDR_W(4), .DEPTH(1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .mem_re(re_b), .mem_addr(addr_b),
        .mem_data(mdata_b), .out_data(odata_b), .out_valid(valid_b), .out_ready(ready_b),
        .busy(busy_b), .done(done_b));

    logic [15:0] mem_a [16];
    logic [15:0] mem_b [16];
    always @(posedge clk) if (re_a) mdata_a <= mem_a[addr_a];
    always @(posedge clk) if (re_b) mdata_b <= mem_b[addr_b];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] exp_a[$], got_a[$], exp_b[$], got_b[$];
    int xcyc_a[$], rise_a[$];
    int re_cnt_a = 0, done_cnt_a = 0, re_cnt_b = 0, done_cnt_b = 0;
    logic pv_a = 1'b0;
    int n_checks = 0, n_fail = 0;

    // monitor: a word is taken when valid and ready are both high ahead of the next rising edge
    always @(negedge clk) begin
        if (valid_a && ready_a) begin
            got_a.push_back(odata_a);
            xcyc_a.push_back(cyc);
        end
        if (valid_a && !pv_a) rise_a.push_back(cyc);
        pv_a = valid_a;
        if (re_a) re_cnt_a++;
        if (done_a) done_cnt_a++;
        if (valid_b && ready_b) got_b.push_back(odata_b);
        if (re_b) re_cnt_b++;
        if (done_b) done_cnt_b++;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_a();
        exp_a.delete();
        got_a.delete();
        xcyc_a.delete();
        rise_a.delete();
        re_cnt_a = 0;
        done_cnt_a = 0;
    endtask

    task automatic load_exp_a();
        for (int i = 0; i < 16; i++) exp_a.push_back(16'h1000 + 16'(i));
    endtask

    task automatic pulse_start_a(input int n);
        start_a = 1'b1;
        step(n);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (done_cnt_a > 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        step(2);
        n_checks += 8;
        if (re_a !== 1'b0) begin n_fail++; $display("FAIL reset_mem_re got %b want 0", re_a); end
        if (addr_a !== 4'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", addr_a); end
        if (odata_a !== 16'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", odata_a); end
        if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", valid_a); end
        if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_a); end
        if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done_a); end
        if (busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_busy_b got %b want 0", busy_b); end
        if (odata_b !== 16'h0) begin n_fail++; $display("FAIL reset_out_data_b got %h want 0", odata_b); end
        rst = 1'b1;
        step(3);
        n_checks++;
        if (busy_a !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset busy got %b want 0", busy_a); end
    endtask

    task automatic test_basic();
        bit ok;
        int t_fall;
        logic [15:0] e, g;
        clear_a();
        load_exp_a();
        ready_a = 1'b1;
        pulse_start_a(2);
        t_fall = cyc;
        wait_done_a(200, ok);
        n_checks += 2;
        if (!ok) begin n_fail++; $display("FAIL basic_timeout got no done want done"); end
        if (got_a.size() != 16) begin n_fail++; $display("FAIL basic_count got %0d want 16", got_a.size()); end
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            g = 16'hxxxx;
            if (got_a.size() > 0) g = got_a.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL basic_word got %h want %h", g, e); end
        end
        n_checks++;
        if (rise_a.size() == 0 || rise_a[0] - t_fall != 3)
            begin n_fail++; $display("FAIL basic_latency got %0d want 3", rise_a.size() ? rise_a[0] - t_fall : -1); end
        for (int i = 1; i < xcyc_a.size(); i++) begin
            n_checks++;
            if (xcyc_a[i] - xcyc_a[i-1] != 3)
                begin n_fail++; $display("FAIL basic_interval got %0d want 3", xcyc_a[i] - xcyc_a[i-1]); end
        end
        step(3);
        n_checks += 3;
        if (done_cnt_a != 1) begin n_fail++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt_a); end
        if (busy_a !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got %b want 0", busy_a); end
        if (re_cnt_a != 16) begin n_fail++; $display("FAIL basic_reads got %0d want 16", re_cnt_a); end
    endtask

    task automatic test_stall();
        bit ok;
        logic [15:0] e, g;
        clear_a();
        load_exp_a();
        ready_a = 1'b1;
        pulse_start_a(2);
        for (int i = 0; i < 100 && got_a.size() < 3; i++) step();
        ready_a = 1'b0;
        for (int i = 0; i < 10 && !valid_a; i++) step();
        for (int k = 0; k < 5; k++) begin
            n_checks += 3;
            if (odata_a !== 16'h1003) begin n_fail++; $display("FAIL stall_data got %h want 1003", odata_a); end
            if (valid_a !== 1'b1) begin n_fail++; $display("FAIL stall_valid got %b want 1", valid_a); end
            if (re_a !== 1'b0) begin n_fail++; $display("FAIL stall_mem_re got %b want 0", re_a); end
            step();
        end
        ready_a = 1'b1;
        wait_done_a(200, ok);
        n_checks += 3;
        if (!ok) begin n_fail++; $display("FAIL stall_timeout got no done want done"); end
        if (got_a.size() != 16) begin n_fail++; $display("FAIL stall_count got %0d want 16", got_a.size()); end
        if (re_cnt_a != 16) begin n_fail++; $display("FAIL stall_reads got %0d want 16", re_cnt_a); end
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            g = 16'hxxxx;
            if (got_a.size() > 0) g = got_a.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL stall_word got %h want %h", g, e); end
        end
        step(2);
    endtask

    task automatic test_start_hold();
        bit ok;
        int t_fall;
        logic [15:0] e, g;
        clear_a();
        load_exp_a();
        ready_a = 1'b1;
        start_a = 1'b1;
        step();
        for (int k = 0; k < 9; k++) begin
            step();
            n_checks += 2;
            if (busy_a !== 1'b1) begin n_fail++; $display("FAIL hold_busy got %b want 1", busy_a); end
            if (valid_a !== 1'b0) begin n_fail++; $display("FAIL hold_valid got %b want 0", valid_a); end
        end
        n_checks++;
        if (re_cnt_a != 0) begin n_fail++; $display("FAIL hold_no_read got %0d want 0", re_cnt_a); end
        start_a = 1'b0;
        t_fall = cyc;
        wait_done_a(200, ok);
        n_checks += 3;
        if (!ok) begin n_fail++; $display("FAIL hold_timeout got no done want done"); end
        if (got_a.size() != 16) begin n_fail++; $display("FAIL hold_count got %0d want 16", got_a.size()); end
        if (rise_a.size() == 0 || rise_a[0] - t_fall != 3)
            begin n_fail++; $display("FAIL hold_latency got %0d want 3", rise_a.size() ? rise_a[0] - t_fall : -1); end
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            g = 16'hxxxx;
            if (got_a.size() > 0) g = got_a.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL hold_word got %h want %h", g, e); end
        end
        step(2);
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [15:0] e, g;
        clear_a();
        ready_a = 1'b1;
        pulse_start_a(2);
        for (int i = 0; i < 100 && got_a.size() < 7; i++) step();
        ready_a = 1'b0;
        for (int i = 0; i < 10 && !valid_a; i++) step();
        n_checks += 2;
        if (odata_a !== 16'h1007) begin n_fail++; $display("FAIL mid_word7 got %h want 1007", odata_a); end
        if (addr_a !== 4'h7) begin n_fail++; $display("FAIL mid_addr7 got %h want 7", addr_a); end
        #2 rst = 1'b0;
        #1;
        n_checks += 6;
        if (re_a !== 1'b0) begin n_fail++; $display("FAIL async_mem_re got %b want 0", re_a); end
        if (addr_a !== 4'h0) begin n_fail++; $display("FAIL async_mem_addr got %h want 0", addr_a); end
        if (odata_a !== 16'h0) begin n_fail++; $display("FAIL async_out_data got %h want 0", odata_a); end
        if (valid_a !== 1'b0) begin n_fail++; $display("FAIL async_out_valid got %b want 0", valid_a); end
        if (busy_a !== 1'b0) begin n_fail++; $display("FAIL async_busy got %b want 0", busy_a); end
        if (done_a !== 1'b0) begin n_fail++; $display("FAIL async_done got %b want 0", done_a); end
        step(3);
        rst = 1'b1;
        ready_a = 1'b1;
        step(4);
        n_checks += 2;
        if (busy_a !== 1'b0) begin n_fail++; $display("FAIL mid_no_autostart got %b want 0", busy_a); end
        if (done_cnt_a != 0) begin n_fail++; $display("FAIL mid_no_done got %0d want 0", done_cnt_a); end
        clear_a();
        load_exp_a();
        pulse_start_a(2);
        wait_done_a(200, ok);
        n_checks += 2;
        if (!ok) begin n_fail++; $display("FAIL restart_timeout got no done want done"); end
        if (got_a.size() != 16) begin n_fail++; $display("FAIL restart_count got %0d want 16", got_a.size()); end
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            g = 16'hxxxx;
            if (got_a.size() > 0) g = got_a.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL restart_word got %h want %h", g, e); end
        end
        step(2);
    endtask

    task automatic test_depth1();
        logic [15:0] g;
        exp_b.push_back(16'hBEEF);
        ready_b = 1'b1;
        start_b = 1'b1;
        step(2);
        start_b = 1'b0;
        for (int i = 0; i < 50 && done_cnt_b == 0; i++) step();
        step(5);
        n_checks += 4;
        if (got_b.size() != 1) begin n_fail++; $display("FAIL d1_count got %0d want 1", got_b.size()); end
        if (re_cnt_b != 1) begin n_fail++; $display("FAIL d1_reads got %0d want 1", re_cnt_b); end
        if (done_cnt_b != 1) begin n_fail++; $display("FAIL d1_done got %0d want 1", done_cnt_b); end
        if (busy_b !== 1'b0) begin n_fail++; $display("FAIL d1_busy got %b want 0", busy_b); end
        g = 16'hxxxx;
        if (got_b.size() > 0) g = got_b.pop_front();
        n_checks++;
        if (g !== exp_b[0]) begin n_fail++; $display("FAIL d1_word got %h want %h", g, exp_b[0]); end
        exp_b.delete();
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [15:0] e, g;
        clear_a();
        load_exp_a();
        ready_a = 1'b1;
        pulse_start_a(2);
        step(20);
        pulse_start_a(2);
        step(10);
        pulse_start_a(3);
        wait_done_a(200, ok);
        step(15);
        n_checks += 5;
        if (!ok) begin n_fail++; $display("FAIL b2b_timeout got no done want done"); end
        if (got_a.size() != 16) begin n_fail++; $display("FAIL b2b_count got %0d want 16", got_a.size()); end
        if (done_cnt_a != 1) begin n_fail++; $display("FAIL b2b_done got %0d want 1", done_cnt_a); end
        if (re_cnt_a != 16) begin n_fail++; $display("FAIL b2b_reads got %0d want 16", re_cnt_a); end
        if (busy_a !== 1'b0) begin n_fail++; $display("FAIL b2b_busy got %b want 0", busy_a); end
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            g = 16'hxxxx;
            if (got_a.size() > 0) g = got_a.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL b2b_word got %h want %h", g, e); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 16'h1000 + 16'(i);
            mem_b[i] = 16'h0;
        end
        mem_b[0] = 16'hBEEF;
        test_reset();
        test_basic();
        test_stall();
        test_start_hold();
        test_reset_mid();
        test_depth1();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
